up_mem_arbiter: RTL and testbench

UP_MEM_ARBITER -- requirements
Module: up_mem_arbiter

---
 rtl/up_mem_arbiter.sv | 110 +++++++++++
 tb/tb_up_mem_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/up_mem_arbiter.sv
// up_mem_arbiter: round-robin arbiter granting one of three requesters a single memory access.
// The ack pulse is issued in the cycle after DONE, while the grant is still held.
module up_mem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int WAIT = 1
) (
  input  logic            clk,
  input  logic            nRst,
  input  logic [2:0]      req,
  input  logic [2:0]      we,
  input  logic [3*AW-1:0] addr,
  input  logic [3*DW-1:0] wdata,
  output logic [2:0]      gnt,
  output logic [2:0]      ack,
  output logic [DW-1:0]   rdata,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state_q, state_d;
  logic [2:0] gnt_q, gnt_d, ack_q, ack_d, cnt_q, cnt_d;
  logic [1:0] last_q, last_d, c1, c2, win;
  logic [DW-1:0] rdata_q, rdata_d, mem_wdata_q, mem_wdata_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  // Search order last+1, last+2, then last itself.
  always_comb begin
    c1 = last_q == 2'd2 ? 2'd0 : last_q + 2'd1;
    c2 = c1 == 2'd2 ? 2'd0 : c1 + 2'd1;
    win = req[c1] ? c1 : req[c2] ? c2 : last_q;
  end
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    ack_d = ack_q;
    cnt_d = cnt_q;
    last_d = last_q;
    rdata_d = rdata_q;
    mem_en_d = mem_en_q;
    mem_we_d = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        gnt_d = |req ? 3'b001 << win : 3'b000;
        ack_d = 3'b000;
        if (|req) begin
          mem_en_d = 1'b1;
          mem_we_d = we[win];
          mem_addr_d = addr[win*AW +: AW];
          mem_wdata_d = wdata[win*DW +: DW];
          last_d = win;
          cnt_d = 3'd0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 3'(WAIT)) begin
          rdata_d = mem_we_q ? rdata_q : mem_rdata;
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      DONE: begin
        ack_d = gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= IDLE;
      gnt_q <= '0;
      ack_q <= '0;
      cnt_q <= '0;
      last_q <= 2'd2;
      rdata_q <= '0;
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      ack_q <= ack_d;
      cnt_q <= cnt_d;
      last_q <= last_d;
      rdata_q <= rdata_d;
      mem_en_q <= mem_en_d;
      mem_we_q <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end
  assign gnt = gnt_q;
  assign ack = ack_q;
  assign rdata = rdata_q;
  assign mem_en = mem_en_q;
  assign mem_we = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_up_mem_arbiter.sv
// tb_up_mem_arbiter: WAIT=1 and WAIT=0 arbiters driven by shared random stimulus
// and checked every cycle against a transaction-timeline reference model.
module tb_up_mem_arbiter;
  logic clk = 1'b0, nRst = 1'b1;
  logic [2:0] req = '0, we = '0;
  logic [23:0] addr = '0, wdata = '0;
  logic [2:0] gnt[2], ack[2];
  logic [7:0] rdata[2], maddr[2], mwd[2], mrd[2];
  logic men[2], mwe[2];
  logic [7:0] mem[256];
  int n_cmp = 0, n_err = 0;
  // Model: each transaction is a timeline offset d from its arbitration edge.
  bit busy[2];
  int d[2], tw[2], lst[2];
  logic twe[2];
  logic [7:0] taddr[2], twd[2], rd[2];

  always #5 clk = ~clk;

  up_mem_arbiter #(.AW(8), .DW(8), .WAIT(1)) u_w1 (
    .clk(clk), .nRst(nRst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt[0]), .ack(ack[0]), .rdata(rdata[0]), .mem_en(men[0]), .mem_we(mwe[0]),
    .mem_addr(maddr[0]), .mem_wdata(mwd[0]), .mem_rdata(mrd[0]));
  up_mem_arbiter #(.AW(8), .DW(8), .WAIT(0)) u_w0 (
    .clk(clk), .nRst(nRst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt[1]), .ack(ack[1]), .rdata(rdata[1]), .mem_en(men[1]), .mem_we(mwe[1]),
    .mem_addr(maddr[1]), .mem_wdata(mwd[1]), .mem_rdata(mrd[1]));

  function automatic int wt(int u);
    return u == 0 ? 1 : 0;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      busy[u] = 0;
      d[u] = 0;
      lst[u] = 2;
      rd[u] = 8'h00;
    end
  endtask

  task automatic step(int u);
    int w = wt(u);
    bit found = 0;
    if (busy[u]) begin
      d[u]++;
      if (d[u] == w + 3) busy[u] = 0;
    end
    if (busy[u] && d[u] == w + 1 && !twe[u]) rd[u] = mrd[u];
    if (!busy[u] && req != 3'b000) begin
      for (int i = 1; i <= 3; i++) begin
        int c = (lst[u] + i) % 3;
        if (!found && req[c]) begin
          found = 1;
          tw[u] = c;
        end
      end
      lst[u] = tw[u];
      busy[u] = 1;
      d[u] = 0;
      twe[u] = we[tw[u]];
      taddr[u] = addr[tw[u]*8 +: 8];
      twd[u] = wdata[tw[u]*8 +: 8];
    end
  endtask

  task automatic check(int u);
    int w = wt(u);
    logic [2:0] eg = busy[u] ? 3'(1 << tw[u]) : 3'b000;
    logic eme = busy[u] && d[u] <= w;
    chk($sformatf("gnt%0d", u), 32'(gnt[u]), 32'(eg));
    chk($sformatf("ack%0d", u), 32'(ack[u]), 32'((busy[u] && d[u] == w + 2) ? eg : 3'b000));
    chk($sformatf("mem_en%0d", u), 32'(men[u]), 32'(eme));
    chk($sformatf("mem_we%0d", u), 32'(mwe[u]), 32'(eme && twe[u]));
    chk($sformatf("rdata%0d", u), 32'(rdata[u]), 32'(rd[u]));
    if (eme) chk($sformatf("mem_addr%0d", u), 32'(maddr[u]), 32'(taddr[u]));
    if (eme && twe[u]) chk($sformatf("mem_wdata%0d", u), 32'(mwd[u]), 32'(twd[u]));
  endtask

  task automatic chk_rst();
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("rst_gnt%0d", u), 32'(gnt[u]), 32'h0);
      chk($sformatf("rst_ack%0d", u), 32'(ack[u]), 32'h0);
      chk($sformatf("rst_rdata%0d", u), 32'(rdata[u]), 32'h0);
      chk($sformatf("rst_mem_en%0d", u), 32'(men[u]), 32'h0);
      chk($sformatf("rst_mem_we%0d", u), 32'(mwe[u]), 32'h0);
      chk($sformatf("rst_mem_addr%0d", u), 32'(maddr[u]), 32'h0);
      chk($sformatf("rst_mem_wdata%0d", u), 32'(mwd[u]), 32'h0);
    end
  endtask

  // Called at a negedge: drive inputs, run one clock, check #1 after the edge.
  task automatic cyc(logic [2:0] r, logic [2:0] w, logic [23:0] a, logic [23:0] wd);
    req = r;
    we = w;
    addr = a;
    wdata = wd;
    for (int u = 0; u < 2; u++)
      mrd[u] = (busy[u] && d[u] == wt(u)) ? mem[taddr[u]] : 8'($urandom);
    @(posedge clk);
    for (int u = 0; u < 2; u++) step(u);
    #1;
    for (int u = 0; u < 2; u++) check(u);
    @(negedge clk);
  endtask

  task automatic idle(int n);
    repeat (n) cyc(3'b000, 3'b000, 24'h0, 24'h0);
  endtask

  task automatic pulse_reset();
    nRst = 1'b0;
    #1;
    chk_rst();
    model_reset();
    @(posedge clk);
    @(negedge clk);
    nRst = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h10] = 8'hA5;
    for (int u = 0; u < 2; u++) mrd[u] = 8'h00;
    model_reset();
    #2;
    nRst = 1'b0;
    #1;
    chk_rst();
    @(negedge clk);
    nRst = 1'b1;
    cyc(3'b010, 3'b000, 24'h001000, 24'h0);
    idle(6);
    cyc(3'b100, 3'b100, 24'h800000, 24'h3C0000);
    idle(6);
    repeat (16) cyc(3'b111, 3'b000, 24'h302010, 24'h0);
    idle(2);
    cyc(3'b001, 3'b000, 24'h000044, 24'h0);
    idle(6);
    cyc(3'b111, 3'b000, 24'h302010, 24'h0);
    cyc(3'b111, 3'b000, 24'h302010, 24'h0);
    pulse_reset();
    cyc(3'b111, 3'b000, 24'h302010, 24'h0);
    idle(6);
    repeat (400) begin
      logic [2:0] r = $urandom_range(0, 3) == 0 ? 3'b000 : 3'($urandom);
      cyc(r, 3'($urandom), 24'($urandom), 24'($urandom));
    end
    cyc(3'b111, 3'b010, 24'($urandom), 24'($urandom));
    pulse_reset();
    repeat (100) cyc(3'($urandom), 3'($urandom), 24'($urandom), 24'($urandom));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
